gesture_seq_power_ctrl: RTL and testbench
=========================================

# gesture_seq_power_ctrl

Parametrised gesture-sequence power controller, the next generation of the two-key gesture power block. It watches `NUM_KEYS` key inputs for a programmable `SEQ_LEN`-step power-on sequence and a separate power-off sequence, each step bounded by a run-time timeout. It toggles `power_state` on a completed match. It sits between the debounced key front-end and the system power/enable logic.

## Interface
- `NUM_KEYS`, default 4: number of key inputs, minimum 2.
- `SEQ_LEN`, default 3: steps per gesture, minimum 1.
- `CNT_W`, default 32: width of the timeout counters.
- `KEY_IDX_W`, derived as `$clog2(NUM_KEYS)`: width of one sequence entry. Not overridable.
- `clk`, in, 1: system clock. The block uses one clock.
- `reset`, in, 1: reset, asynchronous, active-low.
- `key`, in, `NUM_KEYS`: key levels, already synchronised and debounced upstream.
- `on_seq`, in, `SEQ_LEN*KEY_IDX_W`: power-on key indices. Step i is at bits `[i*KEY_IDX_W +: KEY_IDX_W]`; step 0 is first.
- `off_seq`, in, `SEQ_LEN*KEY_IDX_W`: power-off key indices, same packing as `on_seq`.
- `step_timeout`, in, `CNT_W`: cycles allowed between steps.
- `idle_timeout`, in, `CNT_W`: auto-off interval. Used only with `GESTURE_AUTO_OFF_EN`.
- `power_state`, out, 1: current power state. 1 means on.
- `power_on_pulse`, out, 1: one-cycle strobe on an off→on transition.
- `power_off_pulse`, out, 1: one-cycle strobe on an on→off transition.
- `busy`, out, 1: high while in TRACK or RELEASE.
- `step_idx`, out, `$clog2(SEQ_LEN+1)`: number of steps matched so far.

## Operation
- **Edge detection.**
  - `key_q` registers `key`.
  - `edge = key & ~key_q`.
  - A "valid edge" is an edge vector with exactly one bit set. Its index is `k`.
  - A multi-bit edge vector is a "bad edge".
- **Target sequence.** Target = `power_state ? off_seq : on_seq`. It is re-evaluated continuously and is stable inside a gesture.
- **States.** IDLE, TRACK, RELEASE.
- **IDLE:**
  - Valid edge with `k == target[0]`:
    - If `SEQ_LEN == 1`, complete the gesture (see Completion).
    - Otherwise go to TRACK, set `step_idx = 1`, load `countdown = step_timeout`.
  - Any other edge is ignored.
- **TRACK, processed in this priority order:**
  1. Valid edge with `k == target[step_idx]`: increment `step_idx` and reload `countdown`. If this was the last step, complete the gesture.
  2. Bad edge, or valid edge with the wrong key: abort to IDLE with `step_idx = 0`. The edge is consumed and does not restart a gesture.
  3. `countdown == 0` with no edge: timeout, go to IDLE with `step_idx = 0`.
  4. Otherwise decrement `countdown`.
- **Completion:**
  - Toggle `power_state`.
  - Assert the matching pulse.
  - Go to RELEASE.
- **RELEASE.** Stay until `key == 0`, then go to IDLE with `step_idx = 0`. This blocks re-triggering from held keys.
- **Step window.** Exactly `step_timeout + 1` cycles after the edge that advanced the step, including the cycle where `countdown` reads 0. A correct edge in that last cycle is accepted. `step_timeout = 0` gives a one-cycle window.
- **Arithmetic.** `countdown` is unsigned `CNT_W` bits and never wraps below 0.
- **Sequence entries.** Entries ≥ `NUM_KEYS` can never match. A gesture containing one always aborts or times out.

## Timing
- **Reset values:**
  - `power_state = 0`, `power_on_pulse = 0`, `power_off_pulse = 0`, `busy = 0`, `step_idx = 0`.
  - State is IDLE and `countdown = 0`.
  - `key_q` resets to all-ones, so keys held through reset release produce no edge.
- **Edge-to-state latency.** A key rising before clock edge n is sampled at n, and the state, `step_idx` and `power_state` update at edge n. Outputs are registered and visible after edge n.
- **Pulses.**
  - Each pulse is high for exactly one cycle, in the same cycle `power_state` first shows its new value.
  - The two pulses are never high together.
- **Reset mid-operation.** Any gesture in progress is discarded immediately, asynchronously.
- **Input stability.** `on_seq`, `off_seq` and `step_timeout` are sampled live. Changing them while `busy` is high is legal; the next comparison or reload uses the new value.

## Configuration
- **Macro:** `GESTURE_AUTO_OFF_EN`.
- **With the macro defined:**
  - An idle counter reloads to `idle_timeout` on any edge, and whenever `power_state == 0`.
  - It decrements while `power_state == 1` and state is IDLE.
  - On reaching 0: `power_state` goes to 0 and `power_off_pulse` fires for one cycle, with no key activity required.
  - `idle_timeout = 0` disables auto-off.
- **Without the macro:** the idle counter is not built and the `idle_timeout` port is ignored. The port list is identical in both builds.

## Structure
- **Shared package `gesture_pkg`:**
  - the state enum `gesture_state_t` (IDLE, TRACK, RELEASE);
  - a helper function returning sequence entry i from a packed vector.
- **Sub-module `gesture_edge_detect`:**
  - parametrised by `NUM_KEYS`;
  - outputs the `edge` vector and an `edge_onehot` flag;
  - `key_q` is held inside it and resets to all-ones.
- **Top module:** FSM, step counter, countdown and optional idle counter.

## Test plan
All scenarios use `NUM_KEYS=4`, `SEQ_LEN=3`, `on_seq` steps = 0,1,3, `off_seq` steps = 3,1,0, `step_timeout=10`.
- **Power on:** pulse key0, key1, key3, each 5 cycles apart → `power_state` 0→1, `power_on_pulse` high for exactly one cycle, `step_idx` reads 1, 2, 3 then 0 after all keys are released.
- **Timeout boundary:** key0, then key1 exactly 11 cycles later → accepted. Repeat with key1 12 cycles later → timeout, `step_idx` returns to 0, no power change.
- **Wrong key / bad edge:** key0, then key2 → abort to IDLE. Key0, then key1 and key3 rising together → abort. `power_state` stays 0 in both cases.
- **Power off and hold:** with power on, run 3,1,0 → `power_off_pulse` fires once. Holding key0 afterwards keeps the block in RELEASE with `busy=1`, and no new gesture starts until all keys are 0.
- **Reset:** assert `reset` with `step_idx=2`, holding key3 through reset release → all outputs 0 and no edge detected from key3.
- **Auto-off (`GESTURE_AUTO_OFF_EN`, `idle_timeout=20`):** power on, then no keys → `power_state` falls and `power_off_pulse` fires 21 cycles after entering IDLE.

Source files
------------

// File: rtl/gesture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : gesture_pkg                                                  |
// | Description : Shared types and helpers for the gesture-sequence power      |
// |               controller: FSM state encoding and packed-sequence access.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package gesture_pkg;

   // Explicit 2-bit encoding keeps the state register width fixed.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRACK   = 2'd1,
      RELEASE = 2'd2
   } gesture_state_t;

   // Upper bound on the packed sequence width accepted by seq_entry.
   localparam int unsigned c_seq_vec_max = 256;

   // Returns entry idx (each entry width bits wide) from a packed sequence,
   // zero-extended to 32 bits so it can be compared against a key index.
   function automatic logic [31:0] seq_entry(
      input logic [c_seq_vec_max-1:0] vec,
      input int unsigned              idx,
      input int unsigned              width
   );
      logic [c_seq_vec_max-1:0] shifted;
      logic [31:0]              mask;
      shifted = vec >> (idx * width);
      mask    = (32'd1 << width) - 32'd1;
      return shifted[31:0] & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gesture_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gesture_edge_detect                                          |
// | Description : Rising-edge detector for the key inputs. Flags whether       |
// |               exactly one key rose this cycle.                             |
// | Revision    : 1.0  initial release                                         |
// | Ports       : clk         - system clock                                   |
// |               reset       - asynchronous active-low reset                  |
// |               key         - synchronised, debounced key levels             |
// |               key_edge    - per-key rising-edge vector                     |
// |               edge_onehot - exactly one bit of key_edge is set             |
// +----------------------------------------------------------------------------+
module gesture_edge_detect #(
   parameter int NUM_KEYS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key,
   output logic [NUM_KEYS-1:0] key_edge,
   output logic                edge_onehot
);

   logic [NUM_KEYS-1:0] key_q;
   logic [NUM_KEYS-1:0] key_d;

   always_comb begin
      key_d = key;
   end

   // Resetting to all-ones means keys held through reset release are seen
   // as already high, so they produce no spurious edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_q <= '1;
      end else begin
         key_q <= key_d;
      end
   end

   assign key_edge = key & ~key_q;

   // Non-zero and clearing the lowest set bit leaves nothing: one-hot.
   assign edge_onehot = (key_edge != '0) &&
                        ((key_edge & (key_edge - NUM_KEYS'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/gesture_seq_power_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gesture_seq_power_ctrl                                       |
// | Description : Gesture-sequence power controller. Matches a programmable    |
// |               SEQ_LEN-step key sequence (on_seq when off, off_seq when on) |
// |               with a per-step timeout and toggles power_state on a match.  |
// |               Optional auto-off is built when GESTURE_AUTO_OFF_EN is       |
// |               defined; otherwise idle_timeout is ignored.                  |
// | Revision    : 1.0  initial release                                         |
// | Ports       : clk, reset (async active-low)                                |
// |               key[NUM_KEYS]            - debounced key levels              |
// |               on_seq / off_seq         - packed key-index sequences        |
// |               step_timeout             - cycles allowed between steps      |
// |               idle_timeout             - auto-off interval (macro only)    |
// |               power_state              - 1 = on                            |
// |               power_on_pulse / power_off_pulse - one-cycle strobes         |
// |               busy                     - gesture tracking or release wait  |
// |               step_idx                 - steps matched so far              |
// +----------------------------------------------------------------------------+
module gesture_seq_power_ctrl
   import gesture_pkg::*;
#(
   parameter  int NUM_KEYS  = 4,
   parameter  int SEQ_LEN   = 3,
   parameter  int CNT_W     = 32,
   localparam int KEY_IDX_W = $clog2(NUM_KEYS),
   localparam int STEP_W    = $clog2(SEQ_LEN + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_KEYS-1:0]          key,
   input  logic [SEQ_LEN*KEY_IDX_W-1:0] on_seq,
   input  logic [SEQ_LEN*KEY_IDX_W-1:0] off_seq,
   input  logic [CNT_W-1:0]             step_timeout,
   input  logic [CNT_W-1:0]             idle_timeout,
   output logic                         power_state,
   output logic                         power_on_pulse,
   output logic                         power_off_pulse,
   output logic                         busy,
   output logic [STEP_W-1:0]            step_idx
);

   gesture_state_t           state_q, state_d;
   logic [STEP_W-1:0]        step_idx_q, step_idx_d;
   logic [CNT_W-1:0]         countdown_q, countdown_d;
   logic                     power_state_q, power_state_d;
   logic                     power_on_pulse_q, power_on_pulse_d;
   logic                     power_off_pulse_q, power_off_pulse_d;

   logic [NUM_KEYS-1:0]          key_edge;
   logic                         edge_onehot;
   logic [31:0]                  edge_k;
   logic [SEQ_LEN*KEY_IDX_W-1:0] target_seq;
   logic [31:0]                  target_key;
   logic                         key_match;
   logic                         last_step;
   logic                         complete;
   logic                         auto_off_fire;

   gesture_edge_detect #(
      .NUM_KEYS (NUM_KEYS)
   ) u_edge (
      .clk         (clk),
      .reset       (reset),
      .key         (key),
      .key_edge    (key_edge),
      .edge_onehot (edge_onehot)
   );

   // Index of the rising key; only meaningful when edge_onehot is set.
   always_comb begin
      edge_k = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (key_edge[i]) begin
            edge_k = 32'(i);
         end
      end
   end

   // In IDLE step_idx is 0, so one lookup serves both the first step and
   // the later TRACK steps. Entries >= NUM_KEYS never equal edge_k.
   assign target_seq = power_state_q ? off_seq : on_seq;
   assign target_key = seq_entry(c_seq_vec_max'(target_seq), 32'(step_idx_q), KEY_IDX_W);
   assign key_match  = edge_onehot && (edge_k == target_key);
   assign last_step  = (step_idx_q == STEP_W'(SEQ_LEN - 1));

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= IDLE;
         step_idx_q        <= '0;
         countdown_q       <= '0;
         power_state_q     <= 1'b0;
         power_on_pulse_q  <= 1'b0;
         power_off_pulse_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         step_idx_q        <= step_idx_d;
         countdown_q       <= countdown_d;
         power_state_q     <= power_state_d;
         power_on_pulse_q  <= power_on_pulse_d;
         power_off_pulse_q <= power_off_pulse_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      step_idx_d  = step_idx_q;
      countdown_d = countdown_q;
      complete    = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_match) begin
               step_idx_d = step_idx_q + STEP_W'(1);
               if (last_step) begin
                  complete = 1'b1;
                  state_d  = RELEASE;
               end else begin
                  state_d     = TRACK;
                  countdown_d = step_timeout;
               end
            end
         end
         TRACK: begin
            if (key_match) begin
               step_idx_d  = step_idx_q + STEP_W'(1);
               countdown_d = step_timeout;
               if (last_step) begin
                  complete = 1'b1;
                  state_d  = RELEASE;
               end
            end else if (key_edge != '0) begin
               // Wrong key or several keys at once: the edge is consumed.
               state_d    = IDLE;
               step_idx_d = '0;
            end else if (countdown_q == '0) begin
               state_d    = IDLE;
               step_idx_d = '0;
            end else begin
               countdown_d = countdown_q - CNT_W'(1);
            end
         end
         RELEASE: begin
            // Wait for every key to be released so a held key cannot retrigger.
            if (key == '0) begin
               state_d    = IDLE;
               step_idx_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            step_idx_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- auto-off
`ifdef GESTURE_AUTO_OFF_EN
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end

   // Any key activity, or being off, restarts the interval. The count only
   // runs while on and idle; a zero interval disables the feature.
   always_comb begin
      idle_cnt_d    = idle_cnt_q;
      auto_off_fire = 1'b0;
      if ((key_edge != '0) || !power_state_q) begin
         idle_cnt_d = idle_timeout;
      end else if ((state_q == IDLE) && (idle_timeout != '0)) begin
         if (idle_cnt_q == '0) begin
            auto_off_fire = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q - CNT_W'(1);
         end
      end
   end
`else
   logic unused_idle_timeout;
   assign unused_idle_timeout = ^idle_timeout;
   assign auto_off_fire       = 1'b0;
`endif

   // ---------------------------------------------------------------- outputs
   // Completion needs a key edge while auto-off needs none, so at most one
   // of them is active and the pulses can never coincide.
   always_comb begin
      power_state_d     = power_state_q;
      power_on_pulse_d  = 1'b0;
      power_off_pulse_d = 1'b0;
      if (complete) begin
         power_state_d     = ~power_state_q;
         power_on_pulse_d  = ~power_state_q;
         power_off_pulse_d = power_state_q;
      end else if (auto_off_fire) begin
         power_state_d     = 1'b0;
         power_off_pulse_d = 1'b1;
      end
   end

   assign power_state     = power_state_q;
   assign power_on_pulse  = power_on_pulse_q;
   assign power_off_pulse = power_off_pulse_q;
   assign busy            = (state_q != IDLE);
   assign step_idx        = step_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_gesture_seq_power_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gesture_seq_power_ctrl                                    |
// | Description : Self-checking bench for gesture_seq_power_ctrl with a        |
// |               behavioural model (matched-step count plus elapsed cycles).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_gesture_seq_power_ctrl;

   localparam int NUM_KEYS = 4;
   localparam int SEQ_LEN  = 3;
   localparam int CNT_W    = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key;
   logic [5:0]  on_seq;
   logic [5:0]  off_seq;
   logic [31:0] step_timeout;
   logic [31:0] idle_timeout;
   logic        power_state;
   logic        power_on_pulse;
   logic        power_off_pulse;
   logic        busy;
   logic [1:0]  step_idx;

   gesture_seq_power_ctrl #(
      .NUM_KEYS (NUM_KEYS),
      .SEQ_LEN  (SEQ_LEN),
      .CNT_W    (CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .key             (key),
      .on_seq          (on_seq),
      .off_seq         (off_seq),
      .step_timeout    (step_timeout),
      .idle_timeout    (idle_timeout),
      .power_state     (power_state),
      .power_on_pulse  (power_on_pulse),
      .power_off_pulse (power_off_pulse),
      .busy            (busy),
      .step_idx        (step_idx)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: a gesture is "matched steps + cycles since last match";
   // after a completion the model waits for all keys to be released.
   logic [3:0] m_prev;
   bit         m_power;
   bit         m_holding;
   bit         e_on, e_off;
   int         m_matched;
   int         m_last;
   int         m_cyc;
   int         m_to;
   int         m_on [3];
   int         m_off[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic apply_cfg();
      on_seq       = {2'(m_on[2]),  2'(m_on[1]),  2'(m_on[0])};
      off_seq      = {2'(m_off[2]), 2'(m_off[1]), 2'(m_off[0])};
      step_timeout = 32'(m_to);
   endtask

   task automatic model_reset();
      m_prev    = '1;
      m_power   = 1'b0;
      m_holding = 1'b0;
      m_matched = 0;
      e_on      = 1'b0;
      e_off     = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] cur);
      logic [3:0] edges;
      int         k;
      bit         single;
      int         tgt;
      edges  = cur & ~m_prev;
      single = ($countones(edges) == 1);
      k      = 0;
      for (int i = 0; i < 4; i++) if (edges[i]) k = i;
      m_cyc++;
      e_on  = 1'b0;
      e_off = 1'b0;
      if (m_holding) begin
         if (cur == 4'd0) begin
            m_holding = 1'b0;
            m_matched = 0;
         end
      end else begin
         tgt = m_power ? m_off[m_matched] : m_on[m_matched];
         if (single && k == tgt) begin
            m_matched++;
            m_last = m_cyc;
            if (m_matched == SEQ_LEN) begin
               e_on      = !m_power;
               e_off     = m_power;
               m_power   = !m_power;
               m_holding = 1'b1;
            end
         end else if (m_matched > 0) begin
            if (edges != 4'd0) m_matched = 0;
            else if (m_cyc - m_last >= m_to + 1) m_matched = 0;
         end
      end
      m_prev = cur;
   endtask

   task automatic check_all();
      chk("power_state", 32'(power_state), 32'(m_power));
      chk("power_on_pulse", 32'(power_on_pulse), 32'(e_on));
      chk("power_off_pulse", 32'(power_off_pulse), 32'(e_off));
      chk("busy", 32'(busy), 32'(m_holding || m_matched > 0));
      chk("step_idx", 32'(step_idx), m_holding ? 32'(SEQ_LEN) : 32'(m_matched));
   endtask

   task automatic step(input logic [3:0] k);
      key = k;
      @(posedge clk);
      #1;
      model_step(k);
      check_all();
   endtask

   // Called #1 after a clock edge (or at time 0); leaves the bench #1 after an edge.
   task automatic do_reset(input logic [3:0] k);
      key   = k;
      reset = 1'b0;
      #2;
      chk("rst_power_state", 32'(power_state), 32'd0);
      chk("rst_on_pulse", 32'(power_on_pulse), 32'd0);
      chk("rst_off_pulse", 32'(power_off_pulse), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_step_idx", 32'(step_idx), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      m_on  = '{0, 1, 3};
      m_off = '{3, 1, 0};
      m_to  = 10;
      m_cyc = 0;
      m_last = 0;
      idle_timeout = '0;
      apply_cfg();
      do_reset(4'd0);
      step(4'd0);

      // Timeout boundary: 11 cycles accepted, 12 cycles times out.
      step(4'b0001);
      repeat (10) step(4'd0);
      step(4'b0010);
      chk("window_edge_accepted", 32'(step_idx), 32'd2);
      repeat (12) step(4'd0);
      step(4'b0001);
      repeat (11) step(4'd0);
      step(4'b0010);
      chk("window_expired_idx", 32'(step_idx), 32'd0);
      chk("window_expired_pwr", 32'(power_state), 32'd0);
      step(4'd0);

      // Wrong key, then two keys rising together.
      step(4'b0001); step(4'd0); step(4'b0100);
      chk("wrong_key_abort", 32'(step_idx), 32'd0);
      step(4'd0);
      step(4'b0001); step(4'd0); step(4'b1010);
      chk("bad_edge_abort", 32'(busy), 32'd0);
      step(4'd0);

      // Power on: keys 0,1,3 five cycles apart.
      step(4'b0001); repeat (4) step(4'd0);
      step(4'b0010); repeat (4) step(4'd0);
      step(4'b1000);
      chk("power_on_pulse_seen", 32'(power_on_pulse), 32'd1);
      step(4'd0);
      chk("power_on_state", 32'(power_state), 32'd1);
      chk("power_on_idx_cleared", 32'(step_idx), 32'd0);

      // Power off, then hold key0 and press key1 while held.
      step(4'b1000); step(4'd0); step(4'b0010); step(4'd0); step(4'b0001);
      chk("power_off_pulse_seen", 32'(power_off_pulse), 32'd1);
      repeat (3) step(4'b0001);
      step(4'b0011);
      chk("hold_busy", 32'(busy), 32'd1);
      step(4'b0001);
      step(4'd0);
      chk("released_busy", 32'(busy), 32'd0);

      // Reset at step_idx=2 with key3 held through release.
      step(4'b0001); step(4'd0); step(4'b0010);
      chk("pre_reset_idx", 32'(step_idx), 32'd2);
      do_reset(4'b1000);
      step(4'b1000);
      chk("no_edge_after_reset", 32'(busy), 32'd0);
      step(4'd0);

`ifdef GESTURE_AUTO_OFF_EN
      begin
         int n_wait;
         idle_timeout = 32'd20;
         step(4'b0001); step(4'd0); step(4'b0010); step(4'd0); step(4'b1000);
         step(4'd0);
         n_wait = 0;
         key = 4'd0;
         for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (power_off_pulse) begin
               n_wait = n;
               break;
            end
         end
         chk("auto_off_latency", 32'(n_wait), 32'd21);
         chk("auto_off_state", 32'(power_state), 32'd0);
         idle_timeout = '0;
         m_power = 1'b0;
         step(4'd0);
      end
`endif

      // Randomised gestures with live reconfiguration between gestures.
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] nk;
         int         r;
         if (!m_holding && m_matched == 0 && $urandom_range(0, 7) == 0) begin
            m_to = $urandom_range(0, 6);
            for (int i = 0; i < 3; i++) begin
               m_on[i]  = $urandom_range(0, 3);
               m_off[i] = $urandom_range(0, 3);
            end
            apply_cfg();
         end
         if ($urandom_range(0, 599) == 0) begin
            do_reset(4'($urandom_range(0, 15)));
         end
         r = $urandom_range(0, 9);
         if (r <= 3) nk = 4'd0;
         else if (r <= 6 && !m_holding)
            nk = 4'd1 << (m_power ? m_off[m_matched] : m_on[m_matched]);
         else if (r == 7) nk = 4'($urandom_range(0, 15));
         else nk = key;
         step(nk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
